tx_byte_fifo: RTL and testbench
===============================

Name: tx_byte_fifo

Overview:
- Synchronous single-clock byte FIFO that buffers bytes from an upstream producer for the UART transmitter's shift-register loader.
- Write side: plain write strobe, gated by `full`.
- Read side: pop strobe returning a registered data word plus a one-cycle `done` valid pulse.

Parameters:
- DATA_WIDTH, 8: bits per entry.
- DEPTH, 16: number of entries; must be a power of two, 2 or more.
- ADDR_WIDTH, $clog2(DEPTH): pointer width; derived as a localparam, not overridable.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
- rd  input  1  pop request.
- wr  input  1  push request.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- done  output  1  one-cycle pulse; data_out holds a freshly popped word.
- overflow  output  1  only with FIFO_ERR_FLAGS_EN (see Optional Feature).
- underflow  output  1  only with FIFO_ERR_FLAGS_EN (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, data_out=0, done=0. Outputs read empty=1, full=0. Storage array is not reset.
- State: storage array of DEPTH x DATA_WIDTH; wr_ptr and rd_ptr of ADDR_WIDTH bits; count of ADDR_WIDTH+1 bits.
- full and empty are combinational decodes of the count register only; no combinational path from rd or wr.
- Write accepted: wr=1 and full=0.
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments and wraps naturally from DEPTH-1 to 0.
- Read accepted: rd=1 and empty=0.
  - data_out <= mem[rd_ptr].
  - rd_ptr increments with natural wrap.
  - done <= 1 in the same edge.
- Read latency: data_out and done are valid one cycle after the edge where rd is sampled high.
- done is low on every cycle without an accepted read.
- data_out holds its last value until the next accepted read.
- A continuously held rd pops one entry per cycle while non-empty, with done high each of those following cycles. The consumer is responsible for deasserting rd.
- Ignored requests:
  - Write while full: ignored; no pointer or count change, data lost.
  - Read while empty: ignored; done stays 0, data_out unchanged.
- Simultaneous rd and wr:
  - Neither blocked: both occur, count unchanged.
  - Empty: only the write occurs; no fall-through, so the data is readable next cycle at the earliest.
  - Full: only the read occurs; the write is rejected.
- Count update: +1 on write-only, -1 on read-only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- Ordering: strict first-in first-out.
- Reset mid-operation: all contents are logically discarded; the first word pushed after reset is the first read.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined: adds outputs overflow and underflow.
  - overflow is set sticky on any wr=1 while full=1.
  - underflow is set sticky on any rd=1 while empty=1.
  - Both are registered, so they are visible the cycle after the offending request.
  - Both are cleared only by rst.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package tx_fifo_pkg holds:
  - default DATA_WIDTH and DEPTH constants;
  - a byte typedef (logic [7:0]) used by the FIFO and the transmitter.
- One natural sub-module: tx_fifo_mem.
  - Simple dual-port register array: synchronous write port; registered read port with read enable.
  - Instantiated once.
  - Pointer, count and flag logic stay in tx_byte_fifo.

Test Plan:
- Reset check: assert rst for 2 cycles -> empty=1, full=0, done=0, data_out=0x00; an rd pulse afterwards gives done=0.
- Single byte: wr with data_in=0xA5 for 1 cycle, then rd for 1 cycle -> empty falls the cycle after the write; data_out=0xA5 and done=1 for exactly one cycle after rd; empty=1 again.
- Fill to full: write 0x01..0x10 (16 bytes) -> full=1 after the 16th; a 17th write of 0xFF is dropped. Reading 16 times returns 0x01..0x10 in order, then empty=1. With FIFO_ERR_FLAGS_EN, overflow=1.
- Wrap-around: write 10, read 10, write 12, read 12 (distinct values) -> order preserved across the pointer wrap; count returns to 0.
- Simultaneous rd/wr:
  - With 3 entries held, rd=wr=1 for 4 cycles -> count stays 3, outputs follow FIFO order.
  - With the FIFO empty, rd=wr=1 for 1 cycle -> done=0, one entry stored.
- Reset mid-stream: push 5 bytes, pulse rst, push 0x3C, read -> data_out=0x3C; underflow/overflow cleared.

Source files
------------

// File: rtl/tx_fifo_pkg.sv
// Shared definitions for the UART transmit byte path.
//   DefaultDataWidth : default bits per FIFO entry
//   DefaultDepth     : default number of FIFO entries
//   byte_t           : byte type shared by the FIFO and the transmitter
package tx_fifo_pkg;

   localparam int unsigned DefaultDataWidth = 8;
   localparam int unsigned DefaultDepth     = 16;

   typedef logic [7:0] byte_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// Simple dual-port register array for the transmit FIFO.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (clears the read register only)
//   wr_en   : write enable, stores wr_data at wr_addr
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable, loads rd_data from rd_addr
//   rd_addr : read address
//   rd_data : registered read data, held while rd_en is low
module tx_fifo_mem
   import tx_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned DEPTH      = DefaultDepth,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // Storage is deliberately left unreset; only the output register is cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/tx_byte_fifo.sv
// Single-clock byte FIFO feeding the UART transmitter's shift-register loader.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   data_in   : write data, captured on an accepted write
//   rd        : pop request
//   wr        : push request
//   data_out  : registered read data, valid when done is high
//   full      : count == DEPTH
//   empty     : count == 0
//   done      : one-cycle pulse after an accepted read
//   overflow  : (FIFO_ERR_FLAGS_EN) sticky, wr seen while full
//   underflow : (FIFO_ERR_FLAGS_EN) sticky, rd seen while empty
module tx_byte_fifo
   import tx_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned DEPTH      = DefaultDepth,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd,
   input  logic                  wr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  done
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  done_q, done_d;
   logic                  wr_acc, rd_acc;

   // Flags decode the count register only, so there is no rd/wr -> flag path.
   assign full  = (count_q == FullCount);
   assign empty = (count_q == '0);

   assign wr_acc = wr && !full;
   assign rd_acc = rd && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      done_d   = rd_acc;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   assign done = done_q;

   tx_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr_q),
      .rd_data (data_out)
   );

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q  || (wr && full);
      underflow_d = underflow_q || (rd && empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Self-checking bench for tx_byte_fifo: directed stimulus, a queue-style
// reference model compared every cycle, plus hand-computed literal checks.
module tb_tx_byte_fifo;

   localparam int Depth = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       rd;
   logic       wr;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       done;
`ifdef FIFO_ERR_FLAGS_EN
   logic       overflow;
   logic       underflow;
`endif

   int errors = 0;
   int checks = 0;
   bit armed  = 1'b0;

   always #5 clk = ~clk;

   tx_byte_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .rd       (rd),
      .wr       (wr),
      .data_out (data_out),
      .full     (full),
      .empty    (empty),
      .done     (done)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow (overflow),
      .underflow(underflow)
`endif
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: unbounded write/read sequence numbers into a big array;
   // occupancy is simply how many words were written but not yet read.
   logic [7:0] m_store [1024];
   int         m_wr_n = 0;
   int         m_rd_n = 0;
   logic [7:0] m_dout = 8'h00;
   logic       m_done = 1'b0;
   logic       m_ovf  = 1'b0;
   logic       m_udf  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_wr_n <= 0;
         m_rd_n <= 0;
         m_dout <= 8'h00;
         m_done <= 1'b0;
         m_ovf  <= 1'b0;
         m_udf  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (wr && (m_wr_n - m_rd_n) < Depth) begin
            m_store[m_wr_n % 1024] <= data_in;
            m_wr_n <= m_wr_n + 1;
         end
         if (rd && (m_wr_n - m_rd_n) > 0) begin
            m_dout <= m_store[m_rd_n % 1024];
            m_done <= 1'b1;
            m_rd_n <= m_rd_n + 1;
         end
         if (wr && (m_wr_n - m_rd_n) == Depth) m_ovf <= 1'b1;
         if (rd && (m_wr_n - m_rd_n) == 0) m_udf <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("cmp_empty", {31'd0, empty}, {31'd0, (m_wr_n - m_rd_n) == 0});
         check("cmp_full", {31'd0, full}, {31'd0, (m_wr_n - m_rd_n) == Depth});
         check("cmp_done", {31'd0, done}, {31'd0, m_done});
         check("cmp_data_out", {24'd0, data_out}, {24'd0, m_dout});
`ifdef FIFO_ERR_FLAGS_EN
         check("cmp_overflow", {31'd0, overflow}, {31'd0, m_ovf});
         check("cmp_underflow", {31'd0, underflow}, {31'd0, m_udf});
`endif
      end
   end

   // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
   task automatic cyc(input logic r, input logic w, input logic [7:0] d);
      rd      = r;
      wr      = w;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rd = 1'b0; wr = 1'b0; data_in = 8'h00;
      @(posedge clk);
      #1;
      armed = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_data_out", {24'd0, data_out}, 32'h00);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 8'h00);
      check("rd_empty_done", {31'd0, done}, 32'd0);

      // Single byte
      cyc(1'b0, 1'b1, 8'hA5);
      check("single_not_empty", {31'd0, empty}, 32'd0);
      cyc(1'b1, 1'b0, 8'h00);
      check("single_data", {24'd0, data_out}, 32'hA5);
      check("single_done", {31'd0, done}, 32'd1);
      check("single_empty_again", {31'd0, empty}, 32'd1);
      cyc(1'b0, 1'b0, 8'h00);
      check("single_done_drop", {31'd0, done}, 32'd0);
      check("single_data_hold", {24'd0, data_out}, 32'hA5);

      // Fill to full, then one dropped write
      for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, 8'(i));
      check("fill_full", {31'd0, full}, 32'd1);
      cyc(1'b0, 1'b1, 8'hFF);
      check("fill_still_full", {31'd0, full}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
      check("fill_overflow", {31'd0, overflow}, 32'd1);
`endif
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, 1'b0, 8'h00);
         check("drain_data", {24'd0, data_out}, 32'(i));
      end
      cyc(1'b0, 1'b0, 8'h00);
      check("drain_empty", {31'd0, empty}, 32'd1);

      // Wrap-around
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i));
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 8'h00);
         check("wrap1_data", {24'd0, data_out}, 32'(8'h20 + i));
      end
      for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i));
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b0, 8'h00);
         check("wrap2_data", {24'd0, data_out}, 32'(8'h40 + i));
      end
      cyc(1'b0, 1'b0, 8'h00);
      check("wrap_empty", {31'd0, empty}, 32'd1);

      // Simultaneous read/write with 3 held
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i));
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, 8'(8'h70 + i));
         check("simul_done", {31'd0, done}, 32'd1);
         check("simul_data", {24'd0, data_out}, (i < 3) ? 32'(8'h60 + i) : 32'h70);
      end
      for (int i = 1; i < 4; i++) begin
         cyc(1'b1, 1'b0, 8'h00);
         check("simul_drain", {24'd0, data_out}, 32'(8'h70 + i));
      end
      cyc(1'b0, 1'b0, 8'h00);

      // Simultaneous read/write while empty: write only
      cyc(1'b1, 1'b1, 8'h99);
      check("simul_empty_done", {31'd0, done}, 32'd0);
      check("simul_empty_stored", {31'd0, empty}, 32'd0);
      cyc(1'b1, 1'b0, 8'h00);
      check("simul_empty_read", {24'd0, data_out}, 32'h99);
      cyc(1'b0, 1'b0, 8'h00);

      // Reset mid-stream
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'hB0 + i));
      rst = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      check("midrst_empty", {31'd0, empty}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
      check("midrst_overflow", {31'd0, overflow}, 32'd0);
      check("midrst_underflow", {31'd0, underflow}, 32'd0);
`endif
      cyc(1'b0, 1'b1, 8'h3C);
      cyc(1'b1, 1'b0, 8'h00);
      check("midrst_data", {24'd0, data_out}, 32'h3C);
      check("midrst_done", {31'd0, done}, 32'd1);
      cyc(1'b0, 1'b0, 8'h00);
      check("midrst_final_empty", {31'd0, empty}, 32'd1);

      @(negedge clk);
      armed = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
